i2c_reg_bank_ctrl: RTL and testbench

//  Register-bank controller behind i2c_simple_slave. Turns the slave's byte

---
 rtl/i2c_reg_bank_ctrl.sv | 170 +++++++++++++++++
 tb/tb_i2c_reg_bank_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_bank_ctrl.sv
// Pointer-addressed register bank behind an I2C byte-level slave.
// Define I2C_REG_BANK_RO_SNAPSHOT_EN to freeze the read-only inputs at each read address phase.
module i2c_reg_bank_ctrl #(
  parameter int NUM_RW = 4,
  parameter int NUM_RO = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            i2c_addr_rw,
  input  logic                  i2c_addr_rw_valid_stb,
  input  logic [7:0]            i2c_data_rx,
  input  logic                  i2c_data_rx_valid_stb,
  output logic [7:0]            i2c_data_tx,
  input  logic                  i2c_data_tx_loaded_stb,
  input  logic                  i2c_data_tx_done_stb,
  input  logic                  i2c_error_stb,
  output logic                  stall,
  output logic [NUM_RW*8-1:0]   rw_regs,
  input  logic [NUM_RO*8-1:0]   ro_regs,
  output logic                  wr_stb,
  output logic [7:0]            wr_idx
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PTR   = 3'd1,
    ST_WR    = 3'd2,
    ST_FETCH = 3'd3,
    ST_RD    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            ptr_q, ptr_d;
  logic [NUM_RW*8-1:0]   rw_regs_q, rw_regs_d;
  logic [7:0]            data_tx_q, data_tx_d;
  logic                  stall_q, stall_d;
  logic                  wr_stb_q, wr_stb_d;
  logic [7:0]            wr_idx_q, wr_idx_d;
  logic [31:0]           ptr_int_s;
  logic [7:0]            rd_val_s;
  logic [NUM_RO*8-1:0]   ro_src_s;
  logic                  unused_s;

`ifdef I2C_REG_BANK_RO_SNAPSHOT_EN
  logic [NUM_RO*8-1:0]   ro_shadow_q, ro_shadow_d;
  assign ro_src_s = ro_shadow_q;
`else
  assign ro_src_s = ro_regs;
`endif

  // Done strobe is informational and the 7-bit address is matched by the slave.
  assign unused_s  = ^{i2c_data_tx_done_stb, i2c_addr_rw[7:1]};
  assign ptr_int_s = {24'd0, ptr_q};

  // Read mux: R/W bank, then RO bank, everything above reads as 8'hFF.
  always_comb begin
    rd_val_s = 8'hFF;
    for (int k = 0; k < NUM_RW; k++) begin
      rd_val_s = (ptr_int_s == k) ? rw_regs_q[8*k +: 8] : rd_val_s;
    end
    for (int k = 0; k < NUM_RO; k++) begin
      rd_val_s = (ptr_int_s == (NUM_RW + k)) ? ro_src_s[8*k +: 8] : rd_val_s;
    end
  end

  // Next-state and datapath; error beats repeated start beats byte strobes.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rw_regs_d = rw_regs_q;
    data_tx_d = data_tx_q;
    wr_stb_d  = 1'b0;
    wr_idx_d  = wr_idx_q;
`ifdef I2C_REG_BANK_RO_SNAPSHOT_EN
    ro_shadow_d = ro_shadow_q;
`endif
    if (i2c_error_stb) begin
      state_d = ST_IDLE;
    end else if (i2c_addr_rw_valid_stb) begin
      if (i2c_addr_rw[0]) begin
        state_d = ST_FETCH;
`ifdef I2C_REG_BANK_RO_SNAPSHOT_EN
        ro_shadow_d = ro_regs;
`endif
      end else begin
        state_d = ST_PTR;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_PTR: begin
          if (i2c_data_rx_valid_stb) begin
            ptr_d   = i2c_data_rx;
            state_d = ST_WR;
          end else begin
            state_d = ST_PTR;
          end
        end
        ST_WR: begin
          if (i2c_data_rx_valid_stb) begin
            if (ptr_int_s < NUM_RW) begin
              for (int k = 0; k < NUM_RW; k++) begin
                rw_regs_d[8*k +: 8] = (ptr_int_s == k) ? i2c_data_rx : rw_regs_q[8*k +: 8];
              end
              wr_stb_d = 1'b1;
              wr_idx_d = ptr_q;
            end else begin
              wr_stb_d = 1'b0;
            end
            ptr_d = ptr_q + 8'd1;
          end else begin
            ptr_d = ptr_q;
          end
        end
        ST_FETCH: begin
          data_tx_d = rd_val_s;
          state_d   = ST_RD;
        end
        ST_RD: begin
          if (i2c_data_tx_loaded_stb) begin
            ptr_d   = ptr_q + 8'd1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_RD;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    stall_d = (state_d == ST_FETCH);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 8'h00;
      rw_regs_q <= '0;
      data_tx_q <= 8'h00;
      stall_q   <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= 8'h00;
`ifdef I2C_REG_BANK_RO_SNAPSHOT_EN
      ro_shadow_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rw_regs_q <= rw_regs_d;
      data_tx_q <= data_tx_d;
      stall_q   <= stall_d;
      wr_stb_q  <= wr_stb_d;
      wr_idx_q  <= wr_idx_d;
`ifdef I2C_REG_BANK_RO_SNAPSHOT_EN
      ro_shadow_q <= ro_shadow_d;
`endif
    end
  end

  assign i2c_data_tx = data_tx_q;
  assign stall       = stall_q;
  assign rw_regs     = rw_regs_q;
  assign wr_stb      = wr_stb_q;
  assign wr_idx      = wr_idx_q;

endmodule

// File: tb/tb_i2c_reg_bank_ctrl.sv
// Directed bench for i2c_reg_bank_ctrl (default NUM_RW=4, NUM_RO=4).
// Honors I2C_REG_BANK_RO_SNAPSHOT_EN for the coherence scenario.
module tb_i2c_reg_bank_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  i2c_addr_rw;
  logic        i2c_addr_rw_valid_stb;
  logic [7:0]  i2c_data_rx;
  logic        i2c_data_rx_valid_stb;
  logic [7:0]  i2c_data_tx;
  logic        i2c_data_tx_loaded_stb;
  logic        i2c_data_tx_done_stb;
  logic        i2c_error_stb;
  logic        stall;
  logic [31:0] rw_regs;
  logic [31:0] ro_regs;
  logic        wr_stb;
  logic [7:0]  wr_idx;

  int tests_run;
  int tests_failed;

  i2c_reg_bank_ctrl #(.NUM_RW(4), .NUM_RO(4)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .i2c_addr_rw            (i2c_addr_rw),
    .i2c_addr_rw_valid_stb  (i2c_addr_rw_valid_stb),
    .i2c_data_rx            (i2c_data_rx),
    .i2c_data_rx_valid_stb  (i2c_data_rx_valid_stb),
    .i2c_data_tx            (i2c_data_tx),
    .i2c_data_tx_loaded_stb (i2c_data_tx_loaded_stb),
    .i2c_data_tx_done_stb   (i2c_data_tx_done_stb),
    .i2c_error_stb          (i2c_error_stb),
    .stall                  (stall),
    .rw_regs                (rw_regs),
    .ro_regs                (ro_regs),
    .wr_stb                 (wr_stb),
    .wr_idx                 (wr_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_addr(input logic [7:0] b);
    i2c_addr_rw = b; i2c_addr_rw_valid_stb = 1'b1; tick(); i2c_addr_rw_valid_stb = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    i2c_data_rx = b; i2c_data_rx_valid_stb = 1'b1; tick(); i2c_data_rx_valid_stb = 1'b0;
  endtask

  task automatic send_loaded();
    i2c_data_tx_loaded_stb = 1'b1; tick(); i2c_data_tx_loaded_stb = 1'b0;
  endtask

  task automatic send_err();
    i2c_error_stb = 1'b1; tick(); i2c_error_stb = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    tests_run++; if (rw_regs !== 32'h0) begin tests_failed++; $display("FAIL reset_rw_regs got %h exp %h", rw_regs, 32'h0); end
    tests_run++; if (i2c_data_tx !== 8'h00) begin tests_failed++; $display("FAIL reset_tx got %h exp %h", i2c_data_tx, 8'h00); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %b exp 0", stall); end
    tests_run++; if (wr_stb !== 1'b0 || wr_idx !== 8'h00) begin tests_failed++; $display("FAIL reset_wr got stb=%b idx=%h exp 0/00", wr_stb, wr_idx); end
  endtask

  task automatic test_write_autoinc();
    send_addr(8'h84); send_rx(8'h01);
    tests_run++; if (wr_stb !== 1'b0) begin tests_failed++; $display("FAIL wr_ptr_byte_stb got %b exp 0", wr_stb); end
    send_rx(8'hA5);
    tests_run++; if (wr_stb !== 1'b1 || wr_idx !== 8'h01) begin tests_failed++; $display("FAIL wr_first got stb=%b idx=%h exp 1/01", wr_stb, wr_idx); end
    tests_run++; if (rw_regs !== 32'h0000A500) begin tests_failed++; $display("FAIL wr_first_regs got %h exp %h", rw_regs, 32'h0000A500); end
    send_rx(8'h5A);
    tests_run++; if (wr_stb !== 1'b1 || wr_idx !== 8'h02) begin tests_failed++; $display("FAIL wr_second got stb=%b idx=%h exp 1/02", wr_stb, wr_idx); end
    tests_run++; if (rw_regs !== 32'h005AA500) begin tests_failed++; $display("FAIL wr_second_regs got %h exp %h", rw_regs, 32'h005AA500); end
    tick();
    tests_run++; if (wr_stb !== 1'b0) begin tests_failed++; $display("FAIL wr_stb_pulse got %b exp 0", wr_stb); end
    // Repeated-start read continues from ptr=3: reg3 (00), then RO reg 4 (10).
    send_addr(8'h85);
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL wr_ptr3_stall got %b exp 1", stall); end
    tick();
    tests_run++; if (i2c_data_tx !== 8'h00 || stall !== 1'b0) begin tests_failed++; $display("FAIL wr_ptr3_tx got %h/%b exp 00/0", i2c_data_tx, stall); end
    send_loaded(); tick();
    tests_run++; if (i2c_data_tx !== 8'h10) begin tests_failed++; $display("FAIL wr_ptr4_tx got %h exp 10", i2c_data_tx); end
    send_err();
  endtask

  task automatic test_read_stream();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h10; exp_b[1] = 8'h11; exp_b[2] = 8'h22;
    send_addr(8'h84); send_rx(8'h04); send_addr(8'h85);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) send_loaded();
      tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL rd_stall_%0d got %b exp 1", i, stall); end
      tick();
      tests_run++; if (i2c_data_tx !== exp_b[i] || stall !== 1'b0) begin tests_failed++; $display("FAIL rd_byte_%0d got %h/%b exp %h/0", i, i2c_data_tx, stall, exp_b[i]); end
    end
    tick(); tick();
    tests_run++; if (i2c_data_tx !== 8'h22 || stall !== 1'b0) begin tests_failed++; $display("FAIL rd_hold got %h/%b exp 22/0", i2c_data_tx, stall); end
    send_err();
  endtask

  task automatic test_ro_unmapped();
    send_addr(8'h84); send_rx(8'h06);
    send_rx(8'h77);
    tests_run++; if (wr_stb !== 1'b0) begin tests_failed++; $display("FAIL ro_wr_stb0 got %b exp 0", wr_stb); end
    send_rx(8'h88); send_rx(8'h99);
    tests_run++; if (wr_stb !== 1'b0 || rw_regs !== 32'h005AA500) begin tests_failed++; $display("FAIL ro_wr_discard got %b/%h exp 0/%h", wr_stb, rw_regs, 32'h005AA500); end
    send_addr(8'h84); send_rx(8'h07); send_addr(8'h85); tick();
    tests_run++; if (i2c_data_tx !== 8'h33) begin tests_failed++; $display("FAIL ro_rd7 got %h exp 33", i2c_data_tx); end
    send_loaded(); tick();
    tests_run++; if (i2c_data_tx !== 8'hFF) begin tests_failed++; $display("FAIL unmapped_rd8 got %h exp FF", i2c_data_tx); end
    send_err();
  endtask

  task automatic test_error_abort();
    send_addr(8'h84); send_rx(8'h00); send_rx(8'h12);
    tests_run++; if (rw_regs !== 32'h005AA512) begin tests_failed++; $display("FAIL err_pre_write got %h exp %h", rw_regs, 32'h005AA512); end
    send_err(); send_rx(8'h34);
    tests_run++; if (wr_stb !== 1'b0 || rw_regs !== 32'h005AA512) begin tests_failed++; $display("FAIL err_rx_ignored got %b/%h exp 0/%h", wr_stb, rw_regs, 32'h005AA512); end
    send_loaded();
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL err_idle_loaded got %b exp 0", stall); end
  endtask

  task automatic test_ptr_wrap();
    send_addr(8'h84); send_rx(8'hFF); send_rx(8'h5C);
    tests_run++; if (wr_stb !== 1'b0) begin tests_failed++; $display("FAIL wrap_ff_stb got %b exp 0", wr_stb); end
    send_rx(8'h3C);
    tests_run++; if (wr_stb !== 1'b1 || wr_idx !== 8'h00 || rw_regs !== 32'h005AA53C) begin tests_failed++; $display("FAIL wrap_reg0 got %b/%h/%h exp 1/00/%h", wr_stb, wr_idx, rw_regs, 32'h005AA53C); end
    send_err();
  endtask

  task automatic test_priority();
    send_addr(8'h84); send_rx(8'h01);
    i2c_addr_rw = 8'h85; i2c_addr_rw_valid_stb = 1'b1; i2c_error_stb = 1'b1; tick();
    i2c_addr_rw_valid_stb = 1'b0; i2c_error_stb = 1'b0;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL prio_err_over_addr got %b exp 0", stall); end
    send_addr(8'h84); send_rx(8'h01);
    i2c_addr_rw = 8'h84; i2c_addr_rw_valid_stb = 1'b1; i2c_data_rx = 8'hEE; i2c_data_rx_valid_stb = 1'b1; tick();
    i2c_addr_rw_valid_stb = 1'b0; i2c_data_rx_valid_stb = 1'b0;
    tests_run++; if (wr_stb !== 1'b0 || rw_regs !== 32'h005AA53C) begin tests_failed++; $display("FAIL prio_addr_over_rx got %b/%h exp 0/%h", wr_stb, rw_regs, 32'h005AA53C); end
    send_err();
  endtask

  task automatic test_reset_mid_write();
    send_addr(8'h84); send_rx(8'h01); send_rx(8'hAA);
    tests_run++; if (wr_idx !== 8'h01 || rw_regs !== 32'h005AAA3C) begin tests_failed++; $display("FAIL rst_pre got %h/%h exp 01/%h", wr_idx, rw_regs, 32'h005AAA3C); end
    rst = 1'b1; tick(); rst = 1'b0;
    tests_run++; if (rw_regs !== 32'h0 || i2c_data_tx !== 8'h00 || stall !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_outputs got %h/%h/%b exp 0/00/0", rw_regs, i2c_data_tx, stall); end
    tests_run++; if (wr_stb !== 1'b0 || wr_idx !== 8'h00) begin tests_failed++; $display("FAIL rst_mid_wr got %b/%h exp 0/00", wr_stb, wr_idx); end
    send_rx(8'h55);
    tests_run++; if (wr_stb !== 1'b0 || rw_regs !== 32'h0) begin tests_failed++; $display("FAIL rst_rx_ignored got %b/%h exp 0/0", wr_stb, rw_regs); end
  endtask

  task automatic test_ro_coherence();
    logic [7:0] exp1;
    logic [7:0] exp2;
`ifdef I2C_REG_BANK_RO_SNAPSHOT_EN
    exp1 = 8'h11; exp2 = 8'h22;
`else
    exp1 = 8'hBB; exp2 = 8'hCC;
`endif
    ro_regs = 32'h33221110;
    send_addr(8'h84); send_rx(8'h04); send_addr(8'h85); tick();
    tests_run++; if (i2c_data_tx !== 8'h10) begin tests_failed++; $display("FAIL coh_byte0 got %h exp 10", i2c_data_tx); end
    ro_regs = 32'hDDCCBBAA;
    send_loaded(); tick();
    tests_run++; if (i2c_data_tx !== exp1) begin tests_failed++; $display("FAIL coh_byte1 got %h exp %h", i2c_data_tx, exp1); end
    send_loaded(); tick();
    tests_run++; if (i2c_data_tx !== exp2) begin tests_failed++; $display("FAIL coh_byte2 got %h exp %h", i2c_data_tx, exp2); end
    send_err();
    ro_regs = 32'h33221110;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b1;
    i2c_addr_rw = 8'h00; i2c_addr_rw_valid_stb = 1'b0;
    i2c_data_rx = 8'h00; i2c_data_rx_valid_stb = 1'b0;
    i2c_data_tx_loaded_stb = 1'b0; i2c_data_tx_done_stb = 1'b0;
    i2c_error_stb = 1'b0;
    ro_regs = 32'h33221110;
    test_reset();
    test_write_autoinc();
    test_read_stream();
    test_ro_unmapped();
    test_error_abort();
    test_ptr_wrap();
    test_priority();
    test_reset_mid_write();
    test_ro_coherence();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
